// File: rtl/tx_serializer.sv
// tx_serializer: pulls words from a TX FIFO and sends them as asynchronous
// serial frames (start, 7 or 8 data bits LSB first, optional parity, stop),
// timed by a 16x baud enable. Frame format is captured with the data word so
// it stays fixed for the whole frame. Assumes FIFO_WIDTH >= 8; only the low
// eight bits of a word are ever transmitted.
module tx_serializer #(
  parameter int FIFO_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  baud_clock,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_n,
  input  logic                  bit8,
  input  logic                  parity_en,
  input  logic                  odd_n_even,
  output logic                  tx,
  output logic                  tx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT1,
    WAIT2,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  txState_t              r_state;
  txState_t              w_nextState;
  logic [3:0]            r_tick;
  logic [2:0]            r_bitCnt;
  logic [FIFO_WIDTH-1:0] r_shift;
  logic                  r_bit8;
  logic                  r_parityEn;
  logic                  r_parityBit;
  logic                  r_tx;
  logic                  w_txNext;
  logic                  w_inFrame;
  logic                  w_bitEnd;
  logic                  w_lastData;
  logic                  w_loadParity;

  // Ticks only advance while a frame is on the line; the 16th pulse closes a bit.
  assign w_inFrame  = (r_state == START) || (r_state == DATA) ||
                      (r_state == PARITY) || (r_state == STOP);
  assign w_bitEnd   = w_inFrame && baud_clock && (r_tick == 4'hF);
  assign w_lastData = (r_bitCnt == (r_bit8 ? 3'd7 : 3'd6));

  // Parity over the bits that will actually be sent; bit 7 is masked in 7-bit mode.
  assign w_loadParity = (^(fifo_data[7:0] & {bit8, 7'h7F})) ^ odd_n_even;

  // The pop strobe is also gated by the empty flag so an empty FIFO is never popped.
  assign fifo_read_n = !((r_state == POP) && !fifo_empty);
  assign tx_busy     = (r_state != IDLE);
  assign tx          = r_tx;

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic for the frame sequence.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!fifo_empty) w_nextState = POP;
      POP:     w_nextState = fifo_empty ? IDLE : WAIT1;
      WAIT1:   w_nextState = WAIT2;
      WAIT2:   w_nextState = START;
      START:   if (w_bitEnd) w_nextState = DATA;
      DATA:    if (w_bitEnd && w_lastData) w_nextState = r_parityEn ? PARITY : STOP;
      PARITY:  if (w_bitEnd) w_nextState = STOP;
      STOP:    if (w_bitEnd) w_nextState = fifo_empty ? IDLE : POP;
      default: w_nextState = IDLE;
    endcase
  end

  // Line level for the coming cycle, derived from the state being entered.
  always_comb begin
    w_txNext = 1'b1;
    case (w_nextState)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = ((r_state == DATA) && w_bitEnd) ? r_shift[1] : r_shift[0];
      PARITY:  w_txNext = r_parityBit;
      default: w_txNext = 1'b1;
    endcase
  end

  // Tick, data-bit counter, shift register, latched frame format and line register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tick      <= 4'd0;
      r_bitCnt    <= 3'd0;
      r_shift     <= '0;
      r_bit8      <= 1'b0;
      r_parityEn  <= 1'b0;
      r_parityBit <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_tx <= w_txNext;

      if ((r_state != START) && (w_nextState == START)) begin
        r_tick <= 4'd0;
      end else if (w_bitEnd) begin
        r_tick <= 4'd0;
      end else if (w_inFrame && baud_clock) begin
        r_tick <= r_tick + 4'd1;
      end

      if (r_state == START) begin
        r_bitCnt <= 3'd0;
      end else if ((r_state == DATA) && w_bitEnd) begin
        r_bitCnt <= r_bitCnt + 3'd1;
      end

      if (r_state == WAIT2) begin
        r_shift     <= fifo_data;
        r_bit8      <= bit8;
        r_parityEn  <= parity_en;
        r_parityBit <= w_loadParity;
      end else if ((r_state == DATA) && w_bitEnd) begin
        r_shift <= {1'b0, r_shift[FIFO_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: drives tx_serializer from a modelled TX FIFO with
// randomized baud pulses and frame formats, and checks every line bit of every
// frame against a frame built from the serial-format rules.
module tb_tx_serializer;

  typedef struct {
    byte unsigned d;
    logic         b8;
    logic         pe;
    logic         odd;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       baud_clock;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_n;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       tx;
  logic       tx_busy;

  int compared   = 0;
  int mismatched = 0;
  int popCount   = 0;
  int pushCount  = 0;
  int badPops    = 0;
  logic baudFast = 1'b0;

  byte unsigned fifoQ[$];
  frame_t       batch[$];
  logic         expBits[$];

  tx_serializer #(.FIFO_WIDTH(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .baud_clock  (baud_clock),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_n (fifo_read_n),
    .bit8        (bit8),
    .parity_en   (parity_en),
    .odd_n_even  (odd_n_even),
    .tx          (tx),
    .tx_busy     (tx_busy)
  );

  // Free-running system clock.
  initial forever #5 clock = ~clock;

  // Baud enable: either every cycle or a random one-in-four pulse.
  initial begin
    baud_clock = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      baud_clock = baudFast ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  end

  // FIFO model: a pop seen during a cycle presents the next word after that edge.
  initial begin
    logic popNow;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    forever begin
      @(negedge clock);
      popNow = (fifo_read_n == 1'b0);
      if (popNow && fifo_empty) badPops++;
      @(posedge clock);
      #1;
      if (popNow && fifoQ.size() > 0) begin
        fifo_data = fifoQ.pop_front();
        popCount++;
      end
      fifo_empty = (fifoQ.size() == 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Expected line bits of one frame: start, data LSB first, optional parity, stop.
  function automatic void buildFrame(input frame_t f);
    logic par;
    int   n;
    expBits.delete();
    expBits.push_back(1'b0);
    n   = f.b8 ? 8 : 7;
    par = f.odd;
    for (int i = 0; i < n; i++) begin
      expBits.push_back(f.d[i]);
      par = par ^ f.d[i];
    end
    if (f.pe) expBits.push_back(par);
    expBits.push_back(1'b1);
  endfunction

  task automatic driveConfig(input frame_t f);
    bit8       = f.b8;
    parity_en  = f.pe;
    odd_n_even = f.odd;
  endtask

  // Checks tx over one bit time (16 baud pulses), starting at the current negedge.
  task automatic checkBit(input string tag, input logic exp, input int stopAfter);
    int   pulses = 0;
    int   cycles = 0;
    logic obs    = exp;
    while (pulses < stopAfter && cycles < 2000) begin
      if (tx !== exp) obs = tx;
      if (baud_clock) pulses++;
      cycles++;
      @(negedge clock);
    end
    if (stopAfter == 16) checkOutput(tag, obs, exp);
    if (pulses < stopAfter) checkOutput({tag, ".timeout"}, pulses, stopAfter);
  endtask

  // Waits (bounded) for the start bit; returns the number of idle-high cycles seen.
  task automatic waitStart(output int gap);
    gap = 0;
    while (tx !== 1'b0 && gap < 400) begin
      gap++;
      @(negedge clock);
    end
  endtask

  // Queues every frame of the batch at once and checks them back to back.
  task automatic applyStimulus(input string name);
    int gap;
    @(negedge clock);
    driveConfig(batch[0]);
    foreach (batch[i]) begin
      fifoQ.push_back(batch[i].d);
      pushCount++;
    end
    for (int f = 0; f < batch.size(); f++) begin
      waitStart(gap);
      if (tx !== 1'b0) begin
        checkOutput($sformatf("%s.f%0d.start", name, f), tx, 0);
        return;
      end
      if (f > 0) checkOutput($sformatf("%s.f%0d.gap", name, f), gap, 3);
      bit8       = $urandom_range(0, 1);
      parity_en  = $urandom_range(0, 1);
      odd_n_even = $urandom_range(0, 1);
      buildFrame(batch[f]);
      for (int b = 0; b < expBits.size(); b++)
        checkBit($sformatf("%s.f%0d.bit%0d", name, f, b), expBits[b], 16);
      if (f < batch.size() - 1) driveConfig(batch[f + 1]);
    end
    checkOutput({name, ".busyAfter"}, tx_busy, 0);
    checkOutput({name, ".txAfter"}, tx, 1);
    checkOutput({name, ".pops"}, popCount, pushCount);
  endtask

  function automatic frame_t mk(input byte unsigned d, input logic b8, input logic pe, input logic odd);
    frame_t f;
    f.d   = d;
    f.b8  = b8;
    f.pe  = pe;
    f.odd = odd;
    return f;
  endfunction

  // Main sequence: reset, directed frames, mid-frame reset, idle soak, random batches.
  initial begin
    int viol;
    reset_n    = 1'b0;
    bit8       = 1'b1;
    parity_en  = 1'b0;
    odd_n_even = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst.tx", tx, 1);
    checkOutput("rst.busy", tx_busy, 0);
    checkOutput("rst.readN", fifo_read_n, 1);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("postRst.busy", tx_busy, 0);

    batch.delete(); batch.push_back(mk(8'h55, 1, 0, 0));
    applyStimulus("x55_8N1");
    batch.delete(); batch.push_back(mk(8'hA3, 1, 1, 0));
    applyStimulus("xA3_8E1");
    batch.delete(); batch.push_back(mk(8'hA3, 1, 1, 1));
    applyStimulus("xA3_8O1");
    batch.delete(); batch.push_back(mk(8'hC1, 0, 1, 0));
    applyStimulus("xC1_7E1");
    baudFast = 1'b1;
    batch.delete(); batch.push_back(mk(8'h01, 1, 0, 0)); batch.push_back(mk(8'h80, 1, 0, 0));
    applyStimulus("b2b_fast");
    baudFast = 1'b0;
    batch.delete(); batch.push_back(mk(8'h01, 1, 0, 0)); batch.push_back(mk(8'h80, 1, 0, 0));
    applyStimulus("b2b");

    // Reset in the middle of the fourth data bit of 0xFF.
    @(negedge clock);
    driveConfig(mk(8'hFF, 1, 0, 0));
    fifoQ.push_back(8'hFF);
    pushCount++;
    begin
      int gap;
      waitStart(gap);
    end
    checkOutput("rstMid.start", tx, 0);
    for (int b = 0; b < 4; b++) checkBit($sformatf("rstMid.bit%0d", b), (b == 0) ? 1'b0 : 1'b1, 16);
    checkBit("rstMid.part", 1'b1, 5);
    reset_n = 1'b0;
    #1;
    checkOutput("rstMid.tx", tx, 1);
    checkOutput("rstMid.busy", tx_busy, 0);
    checkOutput("rstMid.readN", fifo_read_n, 1);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    viol = 0;
    repeat (60) begin
      @(negedge clock);
      if (!fifo_read_n || tx_busy || !tx) viol++;
    end
    checkOutput("rstMid.quiet", viol, 0);
    checkOutput("rstMid.pops", popCount, pushCount);

    // Long idle with baud pulses and an empty FIFO.
    viol = 0;
    repeat (1000) begin
      @(negedge clock);
      if (fifo_read_n !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0) viol++;
    end
    checkOutput("idle1000", viol, 0);

    for (int r = 0; r < 6; r++) begin
      baudFast = ($urandom_range(0, 3) == 0);
      batch.delete();
      repeat ($urandom_range(1, 4))
        batch.push_back(mk(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
      applyStimulus($sformatf("rand%0d", r));
    end

    checkOutput("badPops", badPops, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
